// File: rtl/fifo_stream_upsizer.sv
// fifo_stream_upsizer
// Packs consecutive DATA_WIDTH words into one PACK_RATIO-lane beat on a
// valid/ready stream. Lane 0 holds the oldest word. A partial beat leaves
// on an explicit flush or after TIMEOUT idle cycles, with a contiguous
// keep mask covering the filled lanes.
module fifo_stream_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(PACK_RATIO):0]      fill_level
);

  localparam int IDX_W  = $clog2(PACK_RATIO);
  localparam int FILL_W = IDX_W + 1;
  localparam int BEAT_W = DATA_WIDTH * PACK_RATIO;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PACK_RATIO - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  // Value of the idle counter in the cycle that triggers the timeout flush.
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : IDLE_W'(0);

  // Number of set lanes in a keep mask.
  function automatic logic [FILL_W-1:0] popcount(input logic [PACK_RATIO-1:0] v);
    logic [FILL_W-1:0] n;
    n = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      n = n + {{(FILL_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [BEAT_W-1:0]     beat_q,  beat_d;
  logic [PACK_RATIO-1:0] keep_q,  keep_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  valid_q, valid_d;
  logic [IDLE_W-1:0]     idle_q,  idle_d;
  logic [FILL_W-1:0]     fill_q,  fill_d;

  logic in_acc;
  logic out_acc;
  logic has_fill;

  // Handshake qualifiers: input is accepted whenever no beat is stuck at the output.
  always_comb begin
    in_ready = !rst && !clear && (!valid_q || out_ready);
    in_acc   = in_valid && in_ready;
    out_acc  = valid_q && out_ready;
    has_fill = |keep_q;
  end

  // Next-state: lane packing, beat hand-off, flush and idle timeout.
  always_comb begin
    beat_d  = beat_q;
    keep_d  = keep_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    idle_d  = '0;
    if (valid_q) begin
      if (out_acc) begin
        // Beat leaves; a word arriving in the same cycle starts a fresh beat in lane 0.
        valid_d = 1'b0;
        beat_d  = in_acc ? {{(BEAT_W-DATA_WIDTH){1'b0}}, in_data} : '0;
        keep_d  = in_acc ? {{(PACK_RATIO-1){1'b0}}, 1'b1} : '0;
        idx_d   = in_acc ? IDX_ONE : '0;
      end else begin
        // Stalled beat: everything holds, flush ignored, idle stays at 0.
        valid_d = 1'b1;
      end
    end else begin
      if (in_acc) begin
        beat_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
        keep_d[idx_q] = 1'b1;
        if ((idx_q == LAST_IDX) || flush) begin
          valid_d = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + IDX_ONE;
        end
      end else if (flush && has_fill) begin
        valid_d = 1'b1;
        idx_d   = '0;
      end else if ((TIMEOUT > 0) && has_fill) begin
        if (idle_q == IDLE_LAST) begin
          valid_d = 1'b1;
          idx_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d  = idle_q + IDLE_ONE;
        end
      end else begin
        idle_d = '0;
      end
    end
    fill_d = popcount(keep_d);
  end

  // State register with synchronous reset/clear discarding any partial beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_q  <= '0;
      keep_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      idle_q  <= '0;
      fill_q  <= '0;
    end else begin
      beat_q  <= beat_d;
      keep_q  <= keep_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
      fill_q  <= fill_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    out_data   = beat_q;
    out_keep   = keep_q;
    out_valid  = valid_q;
    fill_level = fill_q;
  end

endmodule

// File: tb/tb_fifo_stream_upsizer.sv
// Self-checking bench for fifo_stream_upsizer (DATA_WIDTH=8, PACK_RATIO=4, TIMEOUT=16).
// A word-queue reference model predicts outputs every cycle; a scoreboard
// checks every accepted beat against the input order.
module tb_fifo_stream_upsizer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fill_level;

  fifo_stream_upsizer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words of the beat under construction, plus a held beat.
  logic [7:0]  m_pend[$];
  bit          m_held = 1'b0;
  logic [31:0] m_hdata = 32'h0;
  logic [3:0]  m_hkeep = 4'h0;
  int          m_hcnt = 0;
  int          m_idle = 0;

  // Scoreboard: words accepted by the DUT but not yet seen in an output beat.
  logic [7:0]  sb[$];
  int          acc_count = 0;

  // Values observed at the last sample point.
  logic        obs_ir;
  logic        obs_ov;
  logic [31:0] obs_data;
  logic [3:0]  obs_keep;
  logic [2:0]  obs_fill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_emit();
    m_hdata = 32'h0;
    m_hkeep = 4'h0;
    for (int i = 0; i < m_pend.size(); i++) begin
      m_hdata[i*8 +: 8] = m_pend[i];
      m_hkeep[i] = 1'b1;
    end
    m_hcnt = m_pend.size();
    m_pend.delete();
    m_held = 1'b1;
    m_idle = 0;
  endtask

  task automatic sb_check_beat();
    bit gap = 1'b0;
    bit bad = 1'b0;
    logic [7:0] exp_w;
    check("keep_nonzero", {31'd0, (obs_keep != 4'h0)}, 32'd1);
    for (int i = 0; i < PR; i++) begin
      if (obs_keep[i]) begin
        if (gap) bad = 1'b1;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_w = sb.pop_front();
          check("sb_lane", {24'd0, obs_data[i*8 +: 8]}, {24'd0, exp_w});
        end
      end else begin
        gap = 1'b1;
        check("sb_pad_zero", {24'd0, obs_data[i*8 +: 8]}, 32'd0);
      end
    end
    check("keep_contig", {31'd0, bad}, 32'd0);
  endtask

  // One clock cycle: drive, sample at negedge, compare with model, advance model.
  task automatic cycle(input bit r, input bit c, input bit iv, input logic [7:0] d,
                       input bit fl, input bit ordy);
    bit exp_ir;
    bit was_held;
    bit in_acc;
    rst = r; clear = c; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    @(negedge clk);
    obs_ir = in_ready; obs_ov = out_valid; obs_data = out_data;
    obs_keep = out_keep; obs_fill = fill_level;
    exp_ir = !r && !c && (!m_held || ordy);
    check("in_ready", {31'd0, obs_ir}, {31'd0, exp_ir});
    check("out_valid", {31'd0, obs_ov}, {31'd0, m_held});
    check("fill_level", {29'd0, obs_fill}, m_held ? m_hcnt : m_pend.size());
    if (m_held) begin
      check("out_data", obs_data, m_hdata);
      check("out_keep", {28'd0, obs_keep}, {28'd0, m_hkeep});
    end
    if (obs_ov && ordy) sb_check_beat();
    if (iv && obs_ir) begin
      sb.push_back(d);
      acc_count++;
    end
    if (r || c) begin
      m_pend.delete(); m_held = 1'b0; m_hcnt = 0; m_idle = 0;
      m_hdata = 32'h0; m_hkeep = 4'h0;
      sb.delete();
    end else begin
      was_held = m_held;
      in_acc = iv && exp_ir;
      if (was_held && !ordy) begin
        m_idle = 0;
      end else begin
        if (was_held) m_held = 1'b0;
        if (in_acc) begin
          m_pend.push_back(d);
          m_idle = 0;
        end
        if (m_pend.size() == PR) model_emit();
        else if (!was_held && fl && m_pend.size() > 0) model_emit();
        else if (!was_held && !in_acc && m_pend.size() > 0 && TO > 0) begin
          m_idle++;
          if (m_idle == TO) model_emit();
        end else m_idle = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          r;
    bit          iv;
    logic [7:0]  d;
    bit          fl;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic [2:0]  e_fill;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int k;
    int words;
    int cyc;
    int burst;
    bit rv;
    bit rr;
    bit rf;

    // Reset then stream 0x01..0x08 with out_ready high.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd1};
    tbl[3]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd2};
    tbl[4]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd3};
    tbl[5]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 3'd4};
    tbl[6]  = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd2};
    tbl[8]  = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd3};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08070605, 4'hF, 3'd4};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      check("tbl_in_ready", {31'd0, obs_ir}, {31'd0, tbl[i].e_ir});
      check("tbl_out_valid", {31'd0, obs_ov}, {31'd0, tbl[i].e_ov});
      check("tbl_fill", {29'd0, obs_fill}, {29'd0, tbl[i].e_fill});
      if (tbl[i].e_ov || tbl[i].e_fill == 3'd0) begin
        check("tbl_out_data", obs_data, tbl[i].e_data);
        check("tbl_out_keep", {28'd0, obs_keep}, {28'd0, tbl[i].e_keep});
      end
    end

    // Timeout: two words then idle; partial beat appears 17 cycles after the last accept.
    cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
    k = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      k++;
    end while (!obs_ov && k < 40);
    check("timeout_latency", k, 32'd17);
    check("timeout_data", obs_data, 32'h0000A2A1);
    check("timeout_keep", {28'd0, obs_keep}, 32'h3);
    check("timeout_fill", {29'd0, obs_fill}, 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush together with the second word, then a flush with nothing buffered.
    cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_valid", {31'd0, obs_ov}, 32'd1);
    check("flush_data", obs_data, 32'h00002211);
    check("flush_keep", {28'd0, obs_keep}, 32'h3);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("empty_flush_valid", {31'd0, obs_ov}, 32'd0);
    check("empty_flush_fill", {29'd0, obs_fill}, 32'd0);

    // Backpressure: full beat held for 10 cycles while input keeps offering a word.
    cycle(1'b0, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      check("stall_valid", {31'd0, obs_ov}, 32'd1);
      check("stall_data", obs_data, 32'hDEADBEEF);
      check("stall_keep", {28'd0, obs_keep}, 32'hF);
      check("stall_in_ready", {31'd0, obs_ir}, 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    check("release_in_ready", {31'd0, obs_ir}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("release_valid", {31'd0, obs_ov}, 32'd0);
    check("release_fill", {29'd0, obs_fill}, 32'd1);
    check("release_lane0", obs_data, 32'h00000055);
    check("release_keep", {28'd0, obs_keep}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-beat discards the partial beat; following words pack cleanly.
    cycle(1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h23, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_fill", {29'd0, obs_fill}, 32'd0);
    check("rst_valid", {31'd0, obs_ov}, 32'd0);
    check("rst_in_ready_after", {31'd0, obs_ir}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_data", obs_data, 32'h34333231);
    check("post_rst_keep", {28'd0, obs_keep}, 32'hF);

    // Clear behaves like reset.
    cycle(1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_in_ready", {31'd0, obs_ir}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_fill", {29'd0, obs_fill}, 32'd0);

    // Randomised traffic with occasional flushes and idle bursts.
    words = acc_count;
    cyc = 0;
    burst = 0;
    while ((acc_count - words) < 10000 && cyc < 60000) begin
      if (burst > 0) begin
        rv = 1'b0;
        burst--;
      end else begin
        rv = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 299) == 0) burst = 20;
      end
      rr = ($urandom_range(0, 9) < 6);
      rf = ($urandom_range(0, 49) == 0);
      cycle(1'b0, 1'b0, rv, 8'($urandom), rf, rr);
      cyc++;
    end
    check("random_word_budget", {31'd0, ((acc_count - words) >= 10000)}, 32'd1);

    // Drain whatever is left and confirm no word was lost.
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
